// File: rtl/nco_amp_ramp.sv
// nco_amp_ramp: slews the NCO amplitude word toward a latched target in programmable steps and at a programmable rate, with a ramp-down mute.
// Optional zero-crossing gating of amplitude updates is enabled by defining NCO_AMP_RAMP_ZC_EN.
module nco_amp_ramp #(
   parameter int DAC_WIDTH  = 14,
   parameter int STEP_WIDTH = 10,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DAC_WIDTH-1:0]  target_amp,
   input  logic                  load,
   input  logic                  mute,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic [DIV_WIDTH-1:0]  rate_div,
   input  logic                  nco_sign,
   output logic [DAC_WIDTH-1:0]  amp_out,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   localparam logic [DAC_WIDTH-1:0] AMP_MAX = {1'b0, {(DAC_WIDTH-1){1'b1}}};

   state_t                state_q, state_d;
   logic [DAC_WIDTH-1:0]  amp_q, amp_d;
   logic [DAC_WIDTH-1:0]  target_q, target_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DAC_WIDTH-1:0]  effTgt;
   logic [STEP_WIDTH-1:0] stepEff;
   logic [DAC_WIDTH:0]    stepExt;
   logic [DAC_WIDTH:0]    sumUp;
   logic [DAC_WIDTH:0]    diffDown;
   logic                  tick;
   logic                  zc;
   logic                  hitTgt;

   assign effTgt  = mute ? '0 : target_q;
   assign stepEff = (step == '0) ? STEP_WIDTH'(1) : step;
   assign stepExt = {{(DAC_WIDTH+1-STEP_WIDTH){1'b0}}, stepEff};
   assign tick    = (div_q == rate_div);

`ifdef NCO_AMP_RAMP_ZC_EN
   logic sign_q;

   // Updates land only on a sign change of the NCO sample, i.e. near its zero crossing.
   always_ff @(posedge clk) begin
      if (rst) sign_q <= 1'b0;
      else     sign_q <= nco_sign;
   end

   assign zc = (nco_sign != sign_q);
`else
   logic unusedNcoSign;
   assign unusedNcoSign = nco_sign;
   assign zc = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         amp_q    <= '0;
         target_q <= '0;
         div_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         amp_q    <= amp_d;
         target_q <= target_d;
         div_q    <= div_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Sums are one bit wider than the amplitude so the clamp to the target can never see a wrapped value.
   always_comb begin
      state_d  = state_q;
      amp_d    = amp_q;
      div_d    = div_q;
      hitTgt   = 1'b0;
      target_d = target_q;
      sumUp    = {1'b0, amp_q} + stepExt;
      diffDown = {1'b0, amp_q} - stepExt;
      if (load) target_d = (target_amp > AMP_MAX) ? AMP_MAX : target_amp;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (effTgt > amp_q)      state_d = UP;
            else if (effTgt < amp_q) state_d = DOWN;
         end
         UP, DOWN: begin
            if (effTgt == amp_q) begin
               state_d = IDLE;
               div_d   = '0;
               hitTgt  = 1'b1;
            end else if ((state_q == UP) != (effTgt > amp_q)) begin
               state_d = (effTgt > amp_q) ? UP : DOWN;
               div_d   = '0;
            end else if (tick) begin
               if (zc) begin
                  div_d = '0;
                  if (state_q == UP)
                     amp_d = (sumUp > {1'b0, effTgt}) ? effTgt : sumUp[DAC_WIDTH-1:0];
                  else
                     amp_d = (diffDown[DAC_WIDTH] || (diffDown[DAC_WIDTH-1:0] < effTgt)) ? effTgt : diffDown[DAC_WIDTH-1:0];
                  if (amp_d == effTgt) begin
                     state_d = IDLE;
                     hitTgt  = 1'b1;
                  end
               end
            end else begin
               div_d = div_q + DIV_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = hitTgt;
   end

   assign amp_out = amp_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_nco_amp_ramp.sv
// Self-checking bench for nco_amp_ramp: directed ramps plus randomized traffic against a behavioural model.
// Honours NCO_AMP_RAMP_ZC_EN in the model so the same bench serves both builds.
module tb_nco_amp_ramp;

   localparam int AMP_MAX = 8191;

   logic        clock = 1'b0;
   logic        reset;
   logic [13:0] targetAmp;
   logic        load;
   logic        mute;
   logic [9:0]  step;
   logic [15:0] rateDiv;
   logic        ncoSign;
   logic [13:0] ampOut;
   logic        busy;
   logic        done;

   int testsRun    = 0;
   int testsFailed = 0;

   bit muteVal = 1'b0;
   int stepVal = 0;
   int rateVal = 0;

   int mAmp = 0, mTarget = 0, mDir = 0, mWait = 0;
   bit mBusy = 1'b0, mDone = 1'b0, mSign = 1'b0;

   always #5 clock = ~clock;

   nco_amp_ramp dut (
      .clk(clock), .rst(reset), .target_amp(targetAmp), .load(load), .mute(mute),
      .step(step), .rate_div(rateDiv), .nco_sign(ncoSign),
      .amp_out(ampOut), .busy(busy), .done(done)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Model: mDir is the slew direction (+1/-1, 0 when settled), mWait the cycles spent waiting for the next update.
   task automatic modelEdge();
      int eff, sEff, want, nt;
      bit zc;
      eff  = mute ? 0 : mTarget;
      sEff = (step == 0) ? 1 : int'(step);
      nt   = load ? ((int'(targetAmp) > AMP_MAX) ? AMP_MAX : int'(targetAmp)) : mTarget;
`ifdef NCO_AMP_RAMP_ZC_EN
      zc = (ncoSign != mSign);
`else
      zc = 1'b1;
`endif
      mDone = 1'b0;
      if (reset) begin
         mAmp = 0; mTarget = 0; mDir = 0; mWait = 0; mSign = 1'b0; mBusy = 1'b0;
         return;
      end
      want = (eff > mAmp) ? 1 : ((eff < mAmp) ? -1 : 0);
      if (mDir == 0) begin
         if (want != 0) begin mDir = want; mWait = 0; end
      end else if (want == 0) begin
         mDir = 0; mDone = 1'b1;
      end else if (want != mDir) begin
         mDir = want; mWait = 0;
      end else if (mWait == int'(rateDiv)) begin
         if (zc) begin
            if (mDir > 0) mAmp = (mAmp + sEff > eff) ? eff : mAmp + sEff;
            else          mAmp = (mAmp - sEff < eff) ? eff : mAmp - sEff;
            mWait = 0;
            if (mAmp == eff) begin mDir = 0; mDone = 1'b1; end
         end
      end else begin
         mWait++;
      end
      mTarget = nt;
      mSign   = ncoSign;
      mBusy   = (mDir != 0);
   endtask

   task automatic applyStimulus(input bit r, input bit ld, input int tgt, input bit sg);
      reset     = r;
      load      = ld;
      targetAmp = tgt[13:0];
      mute      = muteVal;
      step      = stepVal[9:0];
      rateDiv   = rateVal[15:0];
      ncoSign   = sg;
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      checkOutput("ampModel", int'(ampOut), mAmp);
      checkOutput("busyModel", int'(busy), int'(mBusy));
      checkOutput("doneModel", int'(done), int'(mDone));
   endtask

   task automatic tickOnce(input bit ld, input int tgt);
      applyStimulus(1'b0, ld, tgt, ~ncoSign);
   endtask

   task automatic resetDut();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic waitAmp(input string tag, input int value);
      for (int i = 0; i < 40 && int'(ampOut) != value; i++) tickOnce(1'b0, 0);
      checkOutput(tag, int'(ampOut), value);
   endtask

   task automatic waitDone(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tickOnce(1'b0, 0);
         seen = done;
      end
      checkOutput(tag, int'(seen), 1);
   endtask

   initial begin
      int expAmp, n, doneCnt, tgt;
      reset = 1'b1; load = 1'b0; targetAmp = '0; mute = 1'b0;
      step = '0; rateDiv = '0; ncoSign = 1'b0;

      // Reset with arbitrary inputs, then idle without a load.
      for (int i = 0; i < 3; i++) begin
         muteVal = 1'($urandom_range(0, 1));
         stepVal = $urandom_range(0, 1023);
         applyStimulus(1'b1, 1'b1, $urandom_range(0, 16383), 1'($urandom_range(0, 1)));
         checkOutput("rstAmp", int'(ampOut), 0);
         checkOutput("rstBusy", int'(busy), 0);
         checkOutput("rstDone", int'(done), 0);
      end
      muteVal = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tickOnce(1'b0, 0);
         checkOutput("idleAmp", int'(ampOut), 0);
      end

      // Basic ramp: step 100 every cycle up to 1000.
      stepVal = 100; rateVal = 0;
      tickOnce(1'b1, 1000);
      for (int j = 1; j <= 11; j++) begin
         tickOnce(1'b0, 0);
         expAmp = (j >= 2) ? 100 * (j - 1) : 0;
         checkOutput("basicAmp", int'(ampOut), expAmp);
         checkOutput("basicDone", int'(done), (j == 11) ? 1 : 0);
         checkOutput("basicBusy", int'(busy), (j < 11) ? 1 : 0);
      end

      // Oversized target clamps to AMP_MAX; step 0 moves by one.
      stepVal = 1023;
      tickOnce(1'b1, 9000);
      waitDone("clampDone");
      checkOutput("clampAmp", int'(ampOut), AMP_MAX);
      stepVal = 0;
      tickOnce(1'b1, 8189);
      tickOnce(1'b0, 0);
      tickOnce(1'b0, 0);
      checkOutput("step0a", int'(ampOut), 8190);
      tickOnce(1'b0, 0);
      checkOutput("step0b", int'(ampOut), 8189);
      checkOutput("step0Done", int'(done), 1);

      // Rate divider: step 300, rate_div 3.
      resetDut();
      stepVal = 300; rateVal = 3;
      tickOnce(1'b1, 1000);
      for (int j = 1; j <= 17; j++) begin
         tickOnce(1'b0, 0);
         n = (j < 5) ? 0 : (j - 5) / 4 + 1;
         expAmp = (300 * n > 1000) ? 1000 : 300 * n;
         checkOutput("rateAmp", int'(ampOut), expAmp);
      end
      checkOutput("rateDone", int'(done), 1);

      // Mute reversal mid-ramp, then release.
      resetDut();
      stepVal = 100; rateVal = 0;
      tickOnce(1'b1, 1000);
      waitAmp("reach500", 500);
      muteVal = 1'b1;
      tickOnce(1'b0, 0);
      checkOutput("muteHold", int'(ampOut), 500);
      tickOnce(1'b0, 0);
      checkOutput("muteDown", int'(ampOut), 400);
      waitDone("muteDone");
      checkOutput("muteZero", int'(ampOut), 0);
      muteVal = 1'b0;
      waitDone("unmuteDone");
      checkOutput("unmuteAmp", int'(ampOut), 1000);

      // Retarget down mid-ramp: exactly one done pulse.
      resetDut();
      tickOnce(1'b1, 1000);
      waitAmp("reach600", 600);
      tickOnce(1'b1, 200);
      doneCnt = 0;
      for (int i = 0; i < 25; i++) begin
         tickOnce(1'b0, 0);
         if (done) doneCnt++;
      end
      checkOutput("retgtDones", doneCnt, 1);
      checkOutput("retgtAmp", int'(ampOut), 200);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) muteVal = ~muteVal;
         stepVal = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
         if (mDir == 0 && $urandom_range(0, 3) == 0) rateVal = $urandom_range(0, 4);
         tgt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3000) : $urandom_range(0, 16383);
         applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) == 0),
                       tgt, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
